grid_renderer: RTL and testbench
================================

GRID_RENDERER -- requirements
Module: grid_renderer

Interface
REQ-001 Parameter NUM_ROWS, default 6, number of cell rows; horizontal bars = NUM_ROWS+1.
REQ-002 Parameter NUM_COLS, default 7, number of cell columns; vertical bars = NUM_COLS+1.
REQ-003 Parameters H_PITCH 75, H_THICK 30, V_PITCH 85, V_THICK 45: bar pitch and thickness in pixels (row / column).
REQ-004 Parameters ROW_W 9, COL_W 10: pixel coordinate widths; BLINK_FRAMES 30: frames per blink half-period.
REQ-005 clock  input  1  sole clock; one clock; all logic rising-edge.
REQ-006 reset_L  input  1  reset, synchronous, active-low.
REQ-007 row  input  ROW_W  raster row of presented pixel.
REQ-008 col  input  COL_W  raster column of presented pixel.
REQ-009 pix_valid  input  1  pixel presented this cycle.
REQ-010 mode  input  2  highlight mode: 0 OFF, 1 STEADY, 2 BLINK, 3 treated as OFF.
REQ-011 sel_col  input  $clog2(NUM_COLS)  selected column to highlight.
REQ-012 out_valid  output  1  outputs below describe a pixel.
REQ-013 is_board  output  1  pixel lies on any bar.
REQ-014 in_cell  output  1  pixel lies inside a cell interior.
REQ-015 cell_row / cell_col  output  $clog2(NUM_ROWS) / $clog2(NUM_COLS)  cell indices, 0 when in_cell=0.
REQ-016 is_highlight  output  1  pixel in selected column cell with highlight active.
REQ-017 seq_err  output  1  one-cycle pulse on out-of-sequence pixel.

Function
REQ-018 Column tracker SHALL, on pix_valid: col==0 -> col_phase=0, col_idx=0; else col_phase+1, wrapping to 0 at V_PITCH with col_idx+1; col_idx saturates at NUM_COLS+1.
REQ-019 Row tracker SHALL update only on pix_valid with col==0: row==0 -> row_phase=0, row_idx=0; else same increment/wrap rule with H_PITCH, saturating row_idx at NUM_ROWS+1.
REQ-020 Horizontal bar SHALL be row_phase<H_THICK and row_idx<=NUM_ROWS; vertical bar col_phase<V_THICK and col_idx<=NUM_COLS; is_board = either.
REQ-021 in_cell SHALL be row_phase>=H_THICK, col_phase>=V_THICK, row_idx<NUM_ROWS, col_idx<NUM_COLS.
REQ-022 Pixels beyond the last bar (idx saturated) SHALL give is_board=0, in_cell=0.
REQ-023 Pipeline: stage 1 registers trackers, stage 2 registers decoded outputs; latency exactly 2 clocks from pix_valid to out_valid; no bubbles, no stall.
REQ-024 pix_valid=0 SHALL hold trackers and produce out_valid=0 two cycles later, other outputs 0.
REQ-025 seq_err SHALL pulse when pix_valid, col!=0 and col != last accepted col+1; trackers still increment (no resync until next col==0).
REQ-026 sel_col and mode SHALL be captured only at frame start (pix_valid, row==0, col==0); mid-frame changes have no effect.
REQ-027 Blink counter SHALL count frame starts; at BLINK_FRAMES-1 it clears and toggles blink_on.
REQ-028 is_highlight = in_cell & cell_col==captured sel_col & (STEADY | (BLINK & blink_on)); sel_col>=NUM_COLS never highlights.
REQ-029 Blink counter SHALL run regardless of mode.

Reset
REQ-030 reset_L=0 at a clock edge SHALL clear all trackers, pipeline registers, blink counter, captured mode (OFF) and sel_col (0); set blink_on=1.
REQ-031 All outputs SHALL be 0 during reset and for 2 cycles after release; reset mid-frame SHALL discard in-flight pixels.

Structure
REQ-032 Mode enum (OFF/STEADY/BLINK) and default geometry constants SHALL live in a shared package.
REQ-033 One sub-module, axis_tracker, parametrised by pitch, thickness, count and width, SHALL be instantiated twice (row, column).

Verification
REQ-034 Defaults, row=0, col 0..639 contiguous -> is_board=1 throughout (bar 0), out_valid 2 cycles after each pix_valid.
REQ-035 Row=30, col=44/45/129/130 -> is_board 1/0/1/0; in_cell 0/1/0/1; cell_col -/0/-/1, cell_row 0.
REQ-036 Row=479 -> is_board=1; row=480 -> is_board=0, in_cell=0.
REQ-037 mode=STEADY, sel_col=3 at frame start; pixel row 40, col 300 -> is_highlight=1; col 100 -> 0; sel_col changed mid-frame -> no change.
REQ-038 mode=BLINK, 60 frames -> is_highlight on frames 0-29, off 30-59 for pixels in selected column.
REQ-039 Col jump 10->20 -> seq_err pulse 2 cycles later; reset_L=0 mid-line -> all outputs 0, next frame decodes correctly.

Source files
------------

// File: rtl/grid_renderer_pkg.sv
// Shared types and default geometry for the grid renderer.
package grid_renderer_pkg;

  // Highlight modes; the unused raw code 3 is folded onto MODE_OFF by decode_mode.
  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STEADY = 2'd1,
    MODE_BLINK  = 2'd2
  } mode_e;

  // Default board geometry (7x6 board on a 640x480 raster).
  localparam int DEF_NUM_ROWS     = 6;
  localparam int DEF_NUM_COLS     = 7;
  localparam int DEF_H_PITCH      = 75;
  localparam int DEF_H_THICK      = 30;
  localparam int DEF_V_PITCH      = 85;
  localparam int DEF_V_THICK      = 45;
  localparam int DEF_ROW_W        = 9;
  localparam int DEF_COL_W        = 10;
  localparam int DEF_BLINK_FRAMES = 30;

  // Map a raw 2-bit mode code onto the enum.
  function automatic mode_e decode_mode(input logic [1:0] code);
    mode_e m;
    case (code)
      2'd1:    m = MODE_STEADY;
      2'd2:    m = MODE_BLINK;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

  // Bit width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_tracker.sv
// Tracks position along one raster axis as (bar index, phase within pitch)
// and decodes whether the current position sits on a bar or inside a cell span.
module axis_tracker
  import grid_renderer_pkg::*;
#(
  parameter int PITCH   = 75,
  parameter int THICK   = 30,
  parameter int COUNT   = 6,
  parameter int COORD_W = 9,
  parameter int CELL_W  = width_of(COUNT)
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic               advance,
  input  logic [COORD_W-1:0] coord,
  output logic               on_bar,
  output logic               in_span,
  output logic [CELL_W-1:0]  cell_idx
);

  localparam int PHASE_W = width_of(PITCH);
  // Index runs 0..COUNT+1; COUNT+1 means "past the last bar".
  localparam int IDX_W   = width_of(COUNT + 2);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PITCH - 1);
  localparam logic [PHASE_W-1:0] THICK_V    = PHASE_W'(THICK);
  localparam logic [IDX_W-1:0]   IDX_CELLS  = IDX_W'(COUNT);
  localparam logic [IDX_W-1:0]   IDX_SAT    = IDX_W'(COUNT + 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  // Next position: coordinate 0 restarts, otherwise step and wrap at the pitch.
  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    if (advance) begin
      if (coord == '0) begin
        phase_d = '0;
        idx_d   = '0;
      end else if (phase_q == PHASE_LAST) begin
        phase_d = '0;
        if (idx_q != IDX_SAT) begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  // Bars exist for indices 0..COUNT, cell spans for 0..COUNT-1.
  always_comb begin
    on_bar   = (phase_q < THICK_V) && (idx_q <= IDX_CELLS);
    in_span  = (phase_q >= THICK_V) && (idx_q < IDX_CELLS);
    cell_idx = in_span ? idx_q[CELL_W-1:0] : '0;
  end

endmodule

// File: rtl/grid_renderer.sv
// Classifies each raster pixel against a bar grid: bar / cell interior,
// cell indices, column highlight (steady or blinking) and sequence errors.
// Two-stage pipeline: stage 1 holds trackers, stage 2 holds decoded outputs.
module grid_renderer
  import grid_renderer_pkg::*;
#(
  parameter int NUM_ROWS     = DEF_NUM_ROWS,
  parameter int NUM_COLS     = DEF_NUM_COLS,
  parameter int H_PITCH      = DEF_H_PITCH,
  parameter int H_THICK      = DEF_H_THICK,
  parameter int V_PITCH      = DEF_V_PITCH,
  parameter int V_THICK      = DEF_V_THICK,
  parameter int ROW_W        = DEF_ROW_W,
  parameter int COL_W        = DEF_COL_W,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                        clock,
  input  logic                        reset_L,
  input  logic [ROW_W-1:0]            row,
  input  logic [COL_W-1:0]            col,
  input  logic                        pix_valid,
  input  logic [1:0]                  mode,
  input  logic [$clog2(NUM_COLS)-1:0] sel_col,
  output logic                        out_valid,
  output logic                        is_board,
  output logic                        in_cell,
  output logic [$clog2(NUM_ROWS)-1:0] cell_row,
  output logic [$clog2(NUM_COLS)-1:0] cell_col,
  output logic                        is_highlight,
  output logic                        seq_err
);

  localparam int RC_W    = $clog2(NUM_ROWS);
  localparam int CC_W    = $clog2(NUM_COLS);
  localparam int BLINK_W = width_of(BLINK_FRAMES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  // Stage 1 control state
  logic               valid1_q, valid1_d;
  logic               seq1_q, seq1_d;
  logic [COL_W-1:0]   last_col_q, last_col_d;
  mode_e              mode_q, mode_d;
  logic [CC_W-1:0]    sel_q, sel_d;
  logic               frame_blink_q, frame_blink_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;

  // Stage 2 outputs
  logic               out_valid_q, out_valid_d;
  logic               is_board_q, is_board_d;
  logic               in_cell_q, in_cell_d;
  logic [RC_W-1:0]    cell_row_q, cell_row_d;
  logic [CC_W-1:0]    cell_col_q, cell_col_d;
  logic               is_highlight_q, is_highlight_d;
  logic               seq_err_q, seq_err_d;

  // Tracker decode (from stage 1 registers)
  logic            row_bar, row_span, col_bar, col_span;
  logic [RC_W-1:0] row_cell;
  logic [CC_W-1:0] col_cell;

  logic line_start, frame_start;

  assign line_start  = pix_valid && (col == '0);
  assign frame_start = line_start && (row == '0);

  // Rows only advance on the first pixel of each line.
  axis_tracker #(
    .PITCH   (H_PITCH),
    .THICK   (H_THICK),
    .COUNT   (NUM_ROWS),
    .COORD_W (ROW_W),
    .CELL_W  (RC_W)
  ) u_row_tracker (
    .clock    (clock),
    .reset_L  (reset_L),
    .advance  (line_start),
    .coord    (row),
    .on_bar   (row_bar),
    .in_span  (row_span),
    .cell_idx (row_cell)
  );

  // Columns advance on every accepted pixel.
  axis_tracker #(
    .PITCH   (V_PITCH),
    .THICK   (V_THICK),
    .COUNT   (NUM_COLS),
    .COORD_W (COL_W),
    .CELL_W  (CC_W)
  ) u_col_tracker (
    .clock    (clock),
    .reset_L  (reset_L),
    .advance  (pix_valid),
    .coord    (col),
    .on_bar   (col_bar),
    .in_span  (col_span),
    .cell_idx (col_cell)
  );

  // Stage 1: sequence check, per-frame capture of mode/select, blink counting.
  always_comb begin
    valid1_d      = pix_valid;
    seq1_d        = pix_valid && (col != '0) && (col != COL_W'(last_col_q + 1'b1));
    last_col_d    = pix_valid ? col : last_col_q;
    mode_d        = mode_q;
    sel_d         = sel_q;
    frame_blink_d = frame_blink_q;
    blink_cnt_d   = blink_cnt_q;
    blink_on_d    = blink_on_q;
    if (frame_start) begin
      mode_d        = decode_mode(mode);
      sel_d         = sel_col;
      // The frame uses the blink phase in force before this start is counted.
      frame_blink_d = blink_on_q;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Stage 2: decode tracker state into the pixel classification.
  always_comb begin
    logic hl_active;
    logic sel_ok;
    hl_active      = (mode_q == MODE_STEADY) || ((mode_q == MODE_BLINK) && frame_blink_q);
    sel_ok         = int'(sel_q) < NUM_COLS;
    out_valid_d    = valid1_q;
    is_board_d     = valid1_q && (row_bar || col_bar);
    in_cell_d      = valid1_q && row_span && col_span;
    cell_row_d     = in_cell_d ? row_cell : '0;
    cell_col_d     = in_cell_d ? col_cell : '0;
    is_highlight_d = in_cell_d && sel_ok && (col_cell == sel_q) && hl_active;
    seq_err_d      = valid1_q && seq1_q;
  end

  // Pipeline and frame-state registers.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      valid1_q       <= 1'b0;
      seq1_q         <= 1'b0;
      last_col_q     <= '0;
      mode_q         <= MODE_OFF;
      sel_q          <= '0;
      frame_blink_q  <= 1'b1;
      blink_cnt_q    <= '0;
      blink_on_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      is_board_q     <= 1'b0;
      in_cell_q      <= 1'b0;
      cell_row_q     <= '0;
      cell_col_q     <= '0;
      is_highlight_q <= 1'b0;
      seq_err_q      <= 1'b0;
    end else begin
      valid1_q       <= valid1_d;
      seq1_q         <= seq1_d;
      last_col_q     <= last_col_d;
      mode_q         <= mode_d;
      sel_q          <= sel_d;
      frame_blink_q  <= frame_blink_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_on_q     <= blink_on_d;
      out_valid_q    <= out_valid_d;
      is_board_q     <= is_board_d;
      in_cell_q      <= in_cell_d;
      cell_row_q     <= cell_row_d;
      cell_col_q     <= cell_col_d;
      is_highlight_q <= is_highlight_d;
      seq_err_q      <= seq_err_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign is_board     = is_board_q;
  assign in_cell      = in_cell_q;
  assign cell_row     = cell_row_q;
  assign cell_col     = cell_col_q;
  assign is_highlight = is_highlight_q;
  assign seq_err      = seq_err_q;

endmodule

// File: tb/tb_grid_renderer.sv
// Scoreboard bench for grid_renderer: the driver pushes expected results,
// a monitor pops and compares whenever out_valid is seen.
module tb_grid_renderer;

  localparam int NR = 6;
  localparam int NC = 7;
  localparam int HP = 75;
  localparam int HT = 30;
  localparam int VP = 85;
  localparam int VT = 45;
  localparam int RW = 9;
  localparam int CW = 10;
  localparam int BF = 30;

  logic          clock = 1'b0;
  logic          reset_L = 1'b0;
  logic [RW-1:0] row = '0;
  logic [CW-1:0] col = '0;
  logic          pix_valid = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [2:0]    sel_col = 3'd0;
  logic          out_valid, is_board, in_cell, is_highlight, seq_err;
  logic [2:0]    cell_row, cell_col;

  always #5 clock = ~clock;

  grid_renderer #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .H_PITCH(HP), .H_THICK(HT),
    .V_PITCH(VP), .V_THICK(VT), .ROW_W(RW), .COL_W(CW), .BLINK_FRAMES(BF)
  ) dut (
    .clock        (clock),
    .reset_L      (reset_L),
    .row          (row),
    .col          (col),
    .pix_valid    (pix_valid),
    .mode         (mode),
    .sel_col      (sel_col),
    .out_valid    (out_valid),
    .is_board     (is_board),
    .in_cell      (in_cell),
    .cell_row     (cell_row),
    .cell_col     (cell_col),
    .is_highlight (is_highlight),
    .seq_err      (seq_err)
  );

  typedef struct {
    int unsigned issue;
    logic [9:0]  exp;
    int          r;
    int          c;
  } sb_t;

  sb_t         sb_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;

  // Bench-side frame model state
  int         last_col = 0;
  int         frame_cnt = 0;
  logic [1:0] cap_mode = 2'd0;
  logic [2:0] cap_sel = 3'd0;
  bit         cap_blink = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected flags packed as {board, cell, crow[2:0], ccol[2:0], highlight, seq}.
  function automatic logic [9:0] hb(input logic b, input logic ce, input logic [2:0] cr,
                                    input logic [2:0] cc, input logic hl, input logic sq);
    return {b, ce, cr, cc, hl, sq};
  endfunction

  // Geometry by division, valid for contiguously presented coordinates.
  function automatic logic [9:0] model_exp(input int r, input int c, input logic sq);
    int ri, rp, ci, cp;
    logic b, ce, hl;
    logic [2:0] cr, cc;
    ri = r / HP; if (ri > NR + 1) ri = NR + 1;
    rp = r % HP;
    ci = c / VP; if (ci > NC + 1) ci = NC + 1;
    cp = c % VP;
    b  = ((rp < HT) && (ri <= NR)) || ((cp < VT) && (ci <= NC));
    ce = (rp >= HT) && (cp >= VT) && (ri < NR) && (ci < NC);
    cr = ce ? 3'(ri) : 3'd0;
    cc = ce ? 3'(ci) : 3'd0;
    hl = ce && (ci == int'(cap_sel)) && ((cap_mode == 2'd1) || ((cap_mode == 2'd2) && cap_blink));
    return hb(b, ce, cr, cc, hl, sq);
  endfunction

  // Present one pixel; expectation from the model or from hand-given bits.
  task automatic issue_px(input int r, input int c, input bit use_hand, input logic [9:0] hand);
    sb_t  t;
    logic sq;
    @(negedge clock);
    row       = RW'(r);
    col       = CW'(c);
    pix_valid = 1'b1;
    if (r == 0 && c == 0) begin
      cap_mode  = (mode == 2'd3) ? 2'd0 : mode;
      cap_sel   = sel_col;
      cap_blink = ((frame_cnt / BF) % 2) == 0;
      frame_cnt++;
    end
    sq       = (c != 0) && (c != last_col + 1);
    last_col = c;
    t.issue  = cyc;
    t.exp    = use_hand ? hand : model_exp(r, c, sq);
    t.r      = r;
    t.c      = c;
    sb_q.push_back(t);
  endtask

  task automatic px(input int r, input int c);
    issue_px(r, c, 1'b0, 10'd0);
  endtask

  task automatic line(input int r, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) px(r, c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      pix_valid = 1'b0;
    end
  endtask

  // Reset mid-stream: whatever is still inside the pipeline is dropped.
  task automatic do_reset(input int n);
    @(negedge clock);
    reset_L   = 1'b0;
    pix_valid = 1'b0;
    sb_q.delete();
    last_col  = 0;
    frame_cnt = 0;
    cap_mode  = 2'd0;
    cap_sel   = 3'd0;
    cap_blink = 1'b1;
    repeat (n) @(negedge clock);
    reset_L = 1'b1;
  endtask

  // Monitor: compare on every out_valid, require quiet outputs otherwise.
  sb_t        mon_e;
  logic [9:0] mon_act;
  always begin
    @(posedge clock);
    #1;
    if (mon_en) begin
      mon_act = {is_board, in_cell, cell_row, cell_col, is_highlight, seq_err};
      if (out_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_valid cyc=%0d got flags=%b want no output", cyc, mon_act);
        end else begin
          mon_e = sb_q.pop_front();
          if (cyc != mon_e.issue + 2) begin
            errors++;
            $display("FAIL latency r=%0d c=%0d got=%0d cycles want=2", mon_e.r, mon_e.c, cyc - mon_e.issue);
          end
          checks++;
          if (mon_act !== mon_e.exp) begin
            errors++;
            $display("FAIL pixel r=%0d c=%0d got=%b want=%b (board,cell,crow,ccol,hl,seq)",
                     mon_e.r, mon_e.c, mon_act, mon_e.exp);
          end
        end
      end else begin
        checks++;
        if (mon_act !== 10'd0) begin
          errors++;
          $display("FAIL idle_outputs cyc=%0d got=%b want=0000000000", cyc, mon_act);
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0;
    repeat (3) @(posedge clock);
    mon_en = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_L = 1'b1;
    idle(3);

    // Frame: row 0 is all horizontal bar across the whole line.
    line(0, 0, 638);
    issue_px(0, 639, 1'b1, hb(1, 0, 3'd0, 3'd0, 0, 0));
    for (int r = 1; r < 30; r++) px(r, 0);
    // Row 30: bar/cell edges in columns 0 and 1, with a bubble mid-line.
    line(30, 0, 43);
    issue_px(30, 44, 1'b1, hb(1, 0, 3'd0, 3'd0, 0, 0));
    issue_px(30, 45, 1'b1, hb(0, 1, 3'd0, 3'd0, 0, 0));
    line(30, 46, 128);
    issue_px(30, 129, 1'b1, hb(1, 0, 3'd0, 3'd0, 0, 0));
    issue_px(30, 130, 1'b1, hb(0, 1, 3'd0, 3'd1, 0, 0));
    idle(2);
    line(30, 131, 140);
    for (int r = 31; r < 479; r++) px(r, 0);
    // Last horizontal bar ends at row 479.
    line(479, 0, 44);
    issue_px(479, 45, 1'b1, hb(1, 0, 3'd0, 3'd0, 0, 0));
    line(480, 0, 44);
    issue_px(480, 45, 1'b1, hb(0, 0, 3'd0, 3'd0, 0, 0));
    idle(2);

    // Column jump 10 -> 20 flags a sequence error, 21 follows cleanly.
    line(0, 0, 10);
    issue_px(0, 20, 1'b1, hb(1, 0, 3'd0, 3'd0, 0, 1));
    issue_px(0, 21, 1'b1, hb(1, 0, 3'd0, 3'd0, 0, 0));
    idle(2);

    // STEADY highlight on column 3; mid-frame select/mode changes ignored.
    mode    = 2'd1;
    sel_col = 3'd3;
    px(0, 0);
    for (int r = 1; r < 40; r++) px(r, 0);
    line(40, 0, 99);
    issue_px(40, 100, 1'b1, hb(1, 0, 3'd0, 3'd0, 0, 0));
    line(40, 101, 150);
    sel_col = 3'd1;
    mode    = 2'd0;
    line(40, 151, 299);
    issue_px(40, 300, 1'b1, hb(0, 1, 3'd0, 3'd3, 1, 0));
    px(40, 301);
    idle(2);

    // Reset in the middle of a line, in-flight pixels discarded.
    mode    = 2'd1;
    sel_col = 3'd0;
    px(0, 0);
    for (int r = 1; r <= 30; r++) px(r, 0);
    line(30, 1, 20);
    do_reset(2);
    idle(3);

    // BLINK on column 0: on for frames 0-29, off 30-59, on again at 60.
    mode    = 2'd2;
    sel_col = 3'd0;
    for (int f = 0; f <= 60; f++) begin
      px(0, 0);
      for (int r = 1; r < 30; r++) px(r, 0);
      line(30, 0, 44);
      issue_px(30, 45, 1'b1, hb(0, 1, 3'd0, 3'd0, (f < 30) || (f >= 60), 0));
    end
    idle(4);

    // Every issued pixel must have come out.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
